// File: rtl/sdram_pll_supervisor_pkg.sv
// Shared types and constants for the SDRAM PLL supervisor (package sdram_pll_pkg).
// The FSM state encoding below is visible on state_o and must not be renumbered.
package sdram_pll_pkg;

    typedef enum logic [1:0] {
        RESET_PLL = 2'd0,
        WAIT_LOCK = 2'd1,
        STABLE    = 2'd2,
        RUN       = 2'd3
    } pll_sup_state_t;

    localparam int LOSS_CNT_W = 8;

    // Largest of three cycle counts; sizes the shared sequencing counter.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) begin
            m = b;
        end
        if (c > m) begin
            m = c;
        end
        return m;
    endfunction

endpackage

// File: rtl/sdram_pll_supervisor_if.sv
// Bundle of PLL-facing and system-facing signals of the SDRAM PLL supervisor.
// master = supervisor side, slave = PLL / system side.
interface sdram_pll_supervisor_if;
    import sdram_pll_pkg::*;

    logic                  pll_locked;
    logic                  soft_req;
    logic                  pll_rst;
    logic                  sys_rst_n;
    pll_sup_state_t        state_o;
    logic                  timeout_err;
    logic [LOSS_CNT_W-1:0] loss_cnt;

    modport master (
        input  pll_locked,
        input  soft_req,
        output pll_rst,
        output sys_rst_n,
        output state_o,
        output timeout_err,
        output loss_cnt
    );

    modport slave (
        output pll_locked,
        output soft_req,
        input  pll_rst,
        input  sys_rst_n,
        input  state_o,
        input  timeout_err,
        input  loss_cnt
    );

endinterface

// File: rtl/sdram_pll_supervisor_sync2.sv
// Two-flop synchronizer with asynchronous active-low clear, used for the PLL lock input.
module sdram_pll_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_reg;
    logic sync_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_reg <= 1'b0;
            sync_reg <= 1'b0;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;

endmodule

// File: rtl/sdram_pll_supervisor.sv
// SDRAM PLL supervisor: sequences PLL reset, filters lock, releases sys_rst_n, restarts on loss/timeout.
// Optional loss-of-lock event counter enabled by defining SDRAM_PLL_SUP_LOSS_CNT_EN.
module sdram_pll_supervisor
    import sdram_pll_pkg::*;
#(
    parameter int RST_HOLD_CYCLES     = 4,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 65536
) (
    input  logic                   refclk,
    input  logic                   rst_n,
    sdram_pll_supervisor_if.master bus
);

    localparam int MAX_CYCLES = max3(RST_HOLD_CYCLES, LOCK_STABLE_CYCLES, LOCK_TIMEOUT_CYCLES);
    localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;

    localparam logic [1:0] S_RESET_PLL = RESET_PLL;
    localparam logic [1:0] S_WAIT_LOCK = WAIT_LOCK;
    localparam logic [1:0] S_STABLE    = STABLE;
    localparam logic [1:0] S_RUN       = RUN;

    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(RST_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};

    logic             locked_s;
    logic [1:0]       state_reg;
    logic [1:0]       state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic             pll_rst_reg;
    logic             sys_rst_n_reg;
    logic             timeout_err_reg;
    logic             timeout_err_next;
    logic             restart;

    sdram_pll_sync2 u_lock_sync (
        .clk   (refclk),
        .rst_n (rst_n),
        .d     (bus.pll_locked),
        .q     (locked_s)
    );

    // soft_req overrides every state-specific decision, including a same-edge loss of lock.
    always_comb begin
        state_next       = state_reg;
        timeout_err_next = timeout_err_reg;
        if (bus.soft_req) begin
            state_next = S_RESET_PLL;
        end else begin
            case (state_reg)
                S_RESET_PLL: begin
                    if (cnt_reg == HOLD_LAST) begin
                        state_next = S_WAIT_LOCK;
                    end
                end
                S_WAIT_LOCK: begin
                    if (locked_s) begin
                        state_next = S_STABLE;
                    end else if (cnt_reg == TIMEOUT_LAST) begin
                        state_next       = S_RESET_PLL;
                        timeout_err_next = 1'b1;
                    end
                end
                S_STABLE: begin
                    if (!locked_s) begin
                        state_next = S_WAIT_LOCK;
                    end else if (cnt_reg == STABLE_LAST) begin
                        state_next = S_RUN;
                    end
                end
                S_RUN: begin
                    if (!locked_s) begin
                        state_next = S_RESET_PLL;
                    end
                end
                default: begin
                    state_next = S_RESET_PLL;
                end
            endcase
        end
    end

    // A soft request while already in RESET_PLL re-enters the state and restarts the hold.
    assign restart = bus.soft_req || (state_next != state_reg);

    always_comb begin
        cnt_next = cnt_reg;
        if (restart) begin
            cnt_next = '0;
        end else if (cnt_reg != CNT_MAX) begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    // Outputs are decoded from state_next so they change on the same edge as the state.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= S_RESET_PLL;
            cnt_reg         <= '0;
            pll_rst_reg     <= 1'b1;
            sys_rst_n_reg   <= 1'b0;
            timeout_err_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            cnt_reg         <= cnt_next;
            pll_rst_reg     <= (state_next == S_RESET_PLL);
            sys_rst_n_reg   <= (state_next == S_RUN);
            timeout_err_reg <= timeout_err_next;
        end
    end

`ifdef SDRAM_PLL_SUP_LOSS_CNT_EN
    logic [LOSS_CNT_W-1:0] loss_cnt_reg;
    logic                  loss_event;

    assign loss_event = (state_reg == S_RUN) && !locked_s && !bus.soft_req;

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            loss_cnt_reg <= '0;
        end else if (loss_event && (loss_cnt_reg != {LOSS_CNT_W{1'b1}})) begin
            loss_cnt_reg <= loss_cnt_reg + 1'b1;
        end
    end

    assign bus.loss_cnt = loss_cnt_reg;
`else
    assign bus.loss_cnt = '0;
`endif

    assign bus.state_o     = pll_sup_state_t'(state_reg);
    assign bus.pll_rst     = pll_rst_reg;
    assign bus.sys_rst_n   = sys_rst_n_reg;
    assign bus.timeout_err = timeout_err_reg;

endmodule

// File: tb/tb_sdram_pll_supervisor.sv
// Scoreboard bench for sdram_pll_supervisor: stimulus pushes expected outputs tagged with an edge number,
// a monitor pops and compares them after that edge. Honours SDRAM_PLL_SUP_LOSS_CNT_EN.
module tb_sdram_pll_supervisor;
    import sdram_pll_pkg::*;

`ifdef SDRAM_PLL_SUP_LOSS_CNT_EN
    localparam bit LOSS_EN = 1'b1;
`else
    localparam bit LOSS_EN = 1'b0;
`endif

    localparam logic [1:0] ST_RST  = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_STB  = 2'd2;
    localparam logic [1:0] ST_RUN  = 2'd3;

    typedef struct {
        int         at;
        string      name;
        logic [1:0] st;
        logic       prst;
        logic       srn;
        logic       terr;
        logic [7:0] lcnt;
    } exp_t;

    logic refclk;
    logic rst_n;
    int   edge_cnt;
    int   checks;
    int   failures;
    exp_t exp_q[$];

    sdram_pll_supervisor_if bus_if ();

    sdram_pll_supervisor #(
        .RST_HOLD_CYCLES     (4),
        .LOCK_STABLE_CYCLES  (8),
        .LOCK_TIMEOUT_CYCLES (16)
    ) dut (
        .refclk (refclk),
        .rst_n  (rst_n),
        .bus    (bus_if.master)
    );

    initial begin
        refclk = 1'b0;
        forever #5 refclk = ~refclk;
    end

    initial edge_cnt = 0;
    always @(posedge refclk) edge_cnt <= edge_cnt + 1;

    function automatic logic [7:0] exp_loss(input int n);
        int sat;
        sat = (n > 255) ? 255 : n;
        return LOSS_EN ? 8'(sat) : 8'd0;
    endfunction

    task automatic compare(input string name, input int at, input logic [1:0] st, input logic prst,
                           input logic srn, input logic terr, input logic [7:0] lcnt);
        logic [1:0] got_st;
        got_st = bus_if.state_o;
        checks++;
        if (got_st !== st || bus_if.pll_rst !== prst || bus_if.sys_rst_n !== srn ||
            bus_if.timeout_err !== terr || bus_if.loss_cnt !== lcnt) begin
            failures++;
            $display("FAIL %s edge=%0d got st=%0d pll_rst=%0b sys_rst_n=%0b terr=%0b loss=%0d want st=%0d pll_rst=%0b sys_rst_n=%0b terr=%0b loss=%0d",
                     name, at, got_st, bus_if.pll_rst, bus_if.sys_rst_n, bus_if.timeout_err, bus_if.loss_cnt,
                     st, prst, srn, terr, lcnt);
        end else begin
            $display("ok   %s edge=%0d st=%0d pll_rst=%0b sys_rst_n=%0b terr=%0b loss=%0d",
                     name, at, got_st, bus_if.pll_rst, bus_if.sys_rst_n, bus_if.timeout_err, bus_if.loss_cnt);
        end
    endtask

    task automatic push(input int at, input string name, input logic [1:0] st, input logic prst,
                        input logic srn, input logic terr, input logic [7:0] lcnt);
        exp_t e;
        e.at = at; e.name = name; e.st = st; e.prst = prst;
        e.srn = srn; e.terr = terr; e.lcnt = lcnt;
        exp_q.push_back(e);
    endtask

    // Returns just after the falling edge that follows posedge number target.
    task automatic wait_edge(input int target);
        while (edge_cnt < target) begin
            @(negedge refclk);
            #2;
        end
    endtask

    // Monitor: samples 1 time unit after each falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge refclk);
            #1;
            while (exp_q.size() > 0 && exp_q[0].at <= edge_cnt) begin
                e = exp_q.pop_front();
                if (e.at < edge_cnt) begin
                    checks++;
                    failures++;
                    $display("FAIL %s missed: due edge=%0d sampled at edge=%0d", e.name, e.at, edge_cnt);
                end else begin
                    compare(e.name, e.at, e.st, e.prst, e.srn, e.terr, e.lcnt);
                end
            end
        end
    end

    initial begin
        int base, e0, g, d, f, h, x, lexp;
        checks   = 0;
        failures = 0;
        rst_n = 1'b1;
        bus_if.pll_locked = 1'b1;
        bus_if.soft_req   = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge refclk);
        #2;
        compare("reset_state", edge_cnt, ST_RST, 1'b1, 1'b0, 1'b0, 8'd0);

        // 1: bring-up with lock present from release
        rst_n = 1'b1;
        base = edge_cnt;
        push(base + 3,  "bringup_hold",   ST_RST,  1'b1, 1'b0, 1'b0, 8'd0);
        push(base + 4,  "bringup_wait",   ST_WAIT, 1'b0, 1'b0, 1'b0, 8'd0);
        push(base + 5,  "bringup_stable", ST_STB,  1'b0, 1'b0, 1'b0, 8'd0);
        push(base + 12, "bringup_pre",    ST_STB,  1'b0, 1'b0, 1'b0, 8'd0);
        push(base + 13, "bringup_run",    ST_RUN,  1'b0, 1'b1, 1'b0, 8'd0);
        wait_edge(base + 13);

        // 2: soft restart, then a one-cycle lock glitch while in STABLE
        e0 = edge_cnt;
        bus_if.soft_req = 1'b1;
        push(e0 + 1, "soft_restart", ST_RST,  1'b1, 1'b0, 1'b0, 8'd0);
        push(e0 + 5, "soft_wait",    ST_WAIT, 1'b0, 1'b0, 1'b0, 8'd0);
        push(e0 + 6, "soft_stable",  ST_STB,  1'b0, 1'b0, 1'b0, 8'd0);
        wait_edge(e0 + 1);
        bus_if.soft_req = 1'b0;
        wait_edge(e0 + 7);
        g = edge_cnt;
        bus_if.pll_locked = 1'b0;
        push(g + 3,  "glitch_wait",    ST_WAIT, 1'b0, 1'b0, 1'b0, 8'd0);
        push(g + 4,  "glitch_stable",  ST_STB,  1'b0, 1'b0, 1'b0, 8'd0);
        push(g + 11, "glitch_restart", ST_STB,  1'b0, 1'b0, 1'b0, 8'd0);
        push(g + 12, "glitch_run",     ST_RUN,  1'b0, 1'b1, 1'b0, 8'd0);
        wait_edge(g + 1);
        bus_if.pll_locked = 1'b1;
        wait_edge(g + 12);

        // 3+4: loss in RUN, then lock stays absent into repeated timeouts
        d = edge_cnt;
        bus_if.pll_locked = 1'b0;
        push(d + 2,  "loss_pre",      ST_RUN,  1'b0, 1'b1, 1'b0, 8'd0);
        push(d + 3,  "loss_reset",    ST_RST,  1'b1, 1'b0, 1'b0, exp_loss(1));
        push(d + 6,  "loss_hold",     ST_RST,  1'b1, 1'b0, 1'b0, exp_loss(1));
        push(d + 7,  "loss_wait",     ST_WAIT, 1'b0, 1'b0, 1'b0, exp_loss(1));
        push(d + 22, "timeout_pre",   ST_WAIT, 1'b0, 1'b0, 1'b0, exp_loss(1));
        push(d + 23, "timeout_fire",  ST_RST,  1'b1, 1'b0, 1'b1, exp_loss(1));
        push(d + 27, "timeout_retry", ST_WAIT, 1'b0, 1'b0, 1'b1, exp_loss(1));
        push(d + 43, "timeout_again", ST_RST,  1'b1, 1'b0, 1'b1, exp_loss(1));
        wait_edge(d + 43);
        bus_if.pll_locked = 1'b1;
        push(d + 48, "relock_stable", ST_STB,  1'b0, 1'b0, 1'b1, exp_loss(1));
        push(d + 56, "relock_run",    ST_RUN,  1'b0, 1'b1, 1'b1, exp_loss(1));
        wait_edge(d + 56);

        // 5: soft_req on the same edge the synchronized lock drops
        f = edge_cnt;
        bus_if.pll_locked = 1'b0;
        push(f + 2,  "softloss_pre", ST_RUN, 1'b0, 1'b1, 1'b1, exp_loss(1));
        push(f + 3,  "softloss_rst", ST_RST, 1'b1, 1'b0, 1'b1, exp_loss(1));
        push(f + 16, "softloss_run", ST_RUN, 1'b0, 1'b1, 1'b1, exp_loss(1));
        wait_edge(f + 2);
        bus_if.soft_req = 1'b1;
        wait_edge(f + 3);
        bus_if.soft_req = 1'b0;
        bus_if.pll_locked = 1'b1;
        wait_edge(f + 16);

        // 5b: soft_req with timeout_err already set
        h = edge_cnt;
        bus_if.soft_req = 1'b1;
        push(h + 1,  "soft_terr_rst", ST_RST, 1'b1, 1'b0, 1'b1, exp_loss(1));
        push(h + 14, "soft_terr_run", ST_RUN, 1'b0, 1'b1, 1'b1, exp_loss(1));
        wait_edge(h + 1);
        bus_if.soft_req = 1'b0;
        wait_edge(h + 14);

        // 6: 300 further loss events drive loss_cnt into saturation
        for (int i = 1; i <= 300; i++) begin
            x = edge_cnt;
            lexp = 1 + i;
            bus_if.pll_locked = 1'b0;
            push(x + 3,  "sat_loss", ST_RST, 1'b1, 1'b0, 1'b1, exp_loss(lexp));
            push(x + 16, "sat_run",  ST_RUN, 1'b0, 1'b1, 1'b1, exp_loss(lexp));
            wait_edge(x + 1);
            bus_if.pll_locked = 1'b1;
            wait_edge(x + 16);
        end

        // rst_n asserted mid-RUN with no clock edge before sampling
        rst_n = 1'b0;
        #1;
        compare("async_rst", edge_cnt, ST_RST, 1'b1, 1'b0, 1'b0, 8'd0);
        wait_edge(edge_cnt + 1);
        rst_n = 1'b1;
        base = edge_cnt;
        push(base + 4,  "rerun_wait", ST_WAIT, 1'b0, 1'b0, 1'b0, 8'd0);
        push(base + 13, "rerun_run",  ST_RUN,  1'b0, 1'b1, 1'b0, 8'd0);
        wait_edge(base + 13);

        for (int k = 0; k < 10 && exp_q.size() > 0; k++) begin
            @(negedge refclk);
            #2;
        end
        if (exp_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain pending=%0d want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
